// File: rtl/ddr_write_arbiter_pkg.sv
// ddr_write_arbiter_pkg
//   Shared definitions for the DDR write-path arbiter: FSM state encoding,
//   default widths of the burst address / data beat / byte mask, and the
//   "no byte written" mask value shown to the write-data FIFO when idle.
package ddr_write_arbiter_pkg;

    localparam int ADDR_W_DEF = 31;
    localparam int DATA_W_DEF = 128;
    localparam int MASK_W_DEF = DATA_W_DEF / 8;

    // Mask polarity: 1 = byte NOT written, so all ones masks every byte off.
    localparam logic [MASK_W_DEF-1:0] MASK_ALL_OFF = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT1 = 2'd1,   // address + first data beat
        ST_BEAT2 = 2'd2    // second data beat
    } state_t;

endpackage

// File: rtl/ddr_write_arbiter_rr_arb2.sv
// rr_arb2
//   Two-requester round-robin picker, purely combinational.
//   req    : request vector, bit n = port n
//   rr_ptr : preferred port when both request
//   grant  : one-hot grant (zero when nothing requests)
//   A lone requester always wins; the pointer only breaks ties.
module rr_arb2
    import ddr_write_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ddr_write_arbiter.sv
// ddr_write_arbiter
//   Shares the memory-controller write path (address FIFO + write-data FIFO)
//   between port 0 (line engine) and port 1 (frame filler). Each accepted
//   request is an atomic burst: one address plus two data beats.
//   Ports:
//     clk, rst_n                  clock, async active-low reset
//     req_valid[1:0]/req_ready    per-port handshake, ready is a one-cycle
//                                 combinational accept pulse
//     req_addrN, req_d0_N/d1_N,   burst payload of port N
//     req_m0_N/m1_N
//     af_full, wdf_full           FIFO back-pressure
//     af_addr_din, af_wr_en       address FIFO write side
//     wdf_din, wdf_mask_din,      write-data FIFO write side
//     wdf_wr_en
//     grant_id, busy              status: owner of burst in flight, burst active
module ddr_write_arbiter
    import ddr_write_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_d0_0,
    input  logic [DATA_W-1:0] req_d0_1,
    input  logic [DATA_W-1:0] req_d1_0,
    input  logic [DATA_W-1:0] req_d1_1,
    input  logic [MASK_W-1:0] req_m0_0,
    input  logic [MASK_W-1:0] req_m0_1,
    input  logic [MASK_W-1:0] req_m1_0,
    input  logic [MASK_W-1:0] req_m1_1,
    input  logic              af_full,
    input  logic              wdf_full,
    output logic [ADDR_W-1:0] af_addr_din,
    output logic              af_wr_en,
    output logic [DATA_W-1:0] wdf_din,
    output logic [MASK_W-1:0] wdf_mask_din,
    output logic              wdf_wr_en,
    output logic              grant_id,
    output logic              busy
);

    state_t            state;
    logic              rr_ptr;
    logic [1:0]        grant;
    logic              win;
    logic              beat1_push;
    logic              beat2_push;
    logic              accept;

    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_d0;
    logic [DATA_W-1:0] hold_d1;
    logic [MASK_W-1:0] hold_m0;
    logic [MASK_W-1:0] hold_m1;

    rr_arb2 u_rr_arb2 (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (grant)
    );

    assign win = grant[1];

    // Address and first beat go out together, so both FIFOs must have room.
    assign beat1_push = (state == ST_BEAT1) && !af_full && !wdf_full;
    assign beat2_push = (state == ST_BEAT2) && !wdf_full;

    // A new burst is taken in IDLE or on the cycle the second beat leaves,
    // which gives two cycles per burst back-to-back. Ready is held off while
    // reset is asserted since the FSM sits in IDLE then.
    assign accept    = rst_n && (|req_valid) && ((state == ST_IDLE) || beat2_push);
    assign req_ready = accept ? grant : 2'b00;

    assign af_wr_en  = beat1_push;
    assign wdf_wr_en = beat1_push || beat2_push;
    assign busy      = (state != ST_IDLE);

    assign af_addr_din = hold_addr;
    assign wdf_din     = (state == ST_BEAT2) ? hold_d1 : hold_d0;

    always_comb begin
        wdf_mask_din = hold_m0;
        case (state)
            ST_IDLE:  wdf_mask_din = '1;    // every byte masked off
            ST_BEAT2: wdf_mask_din = hold_m1;
            default:  wdf_mask_din = hold_m0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rr_ptr    <= 1'b0;
            grant_id  <= 1'b0;
            hold_addr <= '0;
            hold_d0   <= '0;
            hold_d1   <= '0;
            hold_m0   <= '0;
            hold_m1   <= '0;
        end else begin
            if (accept) begin
                hold_addr <= win ? req_addr1 : req_addr0;
                hold_d0   <= win ? req_d0_1  : req_d0_0;
                hold_d1   <= win ? req_d1_1  : req_d1_0;
                hold_m0   <= win ? req_m0_1  : req_m0_0;
                hold_m1   <= win ? req_m1_1  : req_m1_0;
                grant_id  <= win;
                rr_ptr    <= ~win;
            end
            case (state)
                ST_IDLE:  if (accept)     state <= ST_BEAT1;
                ST_BEAT1: if (beat1_push) state <= ST_BEAT2;
                ST_BEAT2: if (beat2_push) state <= accept ? ST_BEAT1 : ST_IDLE;
                default:                  state <= ST_IDLE;
            endcase
        end
    end

endmodule
